timer: RTL

Memory-mapped 32-bit timer peripheral that occupies the free slave 2 slot of the `rib` bus in the SoC top level. It consumes slave-side bus transfers (`we_i`/`addr_i`/`data_i`/`data_o`) routed by `rib`. It provides a prescaled up-counter with a compare value, periodic or one-shot mode, and a level interrupt to the core. Firmware uses it for delays and tick generation, alongside `uart` and `gpio`.

---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_prescaler.sv | 29 ++
 rtl/timer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register offsets, CTRL bit positions and the address decoder for
// the timer peripheral.
package timer_pkg;

   localparam logic [7:0] TIMER_CTRL  = 8'h00;
   localparam logic [7:0] TIMER_COUNT = 8'h04;
   localparam logic [7:0] TIMER_VALUE = 8'h08;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_IE      = 1;
   localparam int unsigned CTRL_PEND    = 2;
   localparam int unsigned CTRL_ONESHOT = 3;
   localparam int unsigned CTRL_PRE_LSB = 8;

   typedef enum logic [1:0] {
      REG_CTRL,
      REG_COUNT,
      REG_VALUE,
      REG_NONE
   } reg_sel_e;

   // Only the low address byte is decoded; anything else is unmapped.
   function automatic reg_sel_e decode_offset(input logic [7:0] offset);
      reg_sel_e sel;
      case (offset)
         TIMER_CTRL:  sel = REG_CTRL;
         TIMER_COUNT: sel = REG_COUNT;
         TIMER_VALUE: sel = REG_VALUE;
         default:     sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled and emits a one-cycle tick on
// the terminal count, wrapping back to 0 on that tick.
module timer_prescaler #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pre_cnt;

   assign tick = enable && (pre_cnt == prescale);

   // Prescaler counter: clear has priority, then wrap on tick, else count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (clear || tick) begin
         pre_cnt <= '0;
      end else if (enable) begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/timer.sv
// Memory-mapped 32-bit timer: CTRL/COUNT/VALUE registers, prescaled
// up-counter with compare, periodic or one-shot mode, level interrupt.
module timer #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        int_sig_o
);

   import timer_pkg::*;

   logic                  enable;
   logic                  int_en;
   logic                  pending;
   logic                  oneshot;
   logic [PRESCALE_W-1:0] prescale;
   logic [31:0]           count;
   logic [31:0]           value;

   reg_sel_e              sel;
   logic                  wr_ctrl;
   logic                  wr_count;
   logic                  wr_value;
   logic                  tick;
   logic                  expire;
   logic                  pre_clear;
   logic                  unused_addr;

   assign sel      = decode_offset(addr_i[7:0]);
   assign wr_ctrl  = we_i && (sel == REG_CTRL);
   assign wr_count = we_i && (sel == REG_COUNT);
   assign wr_value = we_i && (sel == REG_VALUE);

   assign unused_addr = ^addr_i[31:8];

   // Writing CTRL with enable low restarts the prescaler phase.
   assign pre_clear = wr_ctrl && !data_i[CTRL_EN];

   timer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .clear    (pre_clear),
      .prescale (prescale),
      .tick     (tick)
   );

   // A software COUNT write on the same edge suppresses the expiry entirely,
   // so neither pending nor the one-shot disable fire in that cycle.
   assign expire = tick && (value != '0) && ((count + 32'd1) == value) && !wr_count;

   // CTRL fields: hardware pending-set beats W1C; one-shot disable beats a
   // written enable of 1 only when the expiry actually happens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable   <= 1'b0;
         int_en   <= 1'b0;
         pending  <= 1'b0;
         oneshot  <= 1'b0;
         prescale <= '0;
      end else begin
         if (wr_ctrl) begin
            enable   <= data_i[CTRL_EN] && !(expire && oneshot);
            int_en   <= data_i[CTRL_IE];
            oneshot  <= data_i[CTRL_ONESHOT];
            prescale <= data_i[CTRL_PRE_LSB +: PRESCALE_W];
         end else if (expire && oneshot) begin
            enable   <= 1'b0;
         end

         if (expire) begin
            pending <= 1'b1;
         end else if (wr_ctrl && data_i[CTRL_PEND]) begin
            pending <= 1'b0;
         end
      end
   end

   // COUNT: software write wins over the tick; otherwise reload or increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (wr_count) begin
         count <= data_i;
      end else if (tick) begin
         count <= expire ? '0 : count + 32'd1;
      end
   end

   // VALUE: plain read/write register; compare this cycle uses the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (wr_value) begin
         value <= data_i;
      end
   end

   // Combinational read mux; unmapped offsets and unused CTRL bits read 0.
   always_comb begin
      data_o = '0;
      case (sel)
         REG_CTRL: begin
            data_o[CTRL_EN]                     = enable;
            data_o[CTRL_IE]                     = int_en;
            data_o[CTRL_PEND]                   = pending;
            data_o[CTRL_ONESHOT]                = oneshot;
            data_o[CTRL_PRE_LSB +: PRESCALE_W]  = prescale;
         end
         REG_COUNT: data_o = count;
         REG_VALUE: data_o = value;
         default:   data_o = '0;
      endcase
   end

   assign int_sig_o = pending && int_en;

endmodule
